// File: rtl/dcache_assoc.sv
// dcache_assoc: N-way set-associative write-back/write-allocate data cache with true LRU and halt flush.
// Optional macro DCACHE_HITCOUNT_EN adds a hit-minus-miss counter written to 0x3100 after the flush.
module dcache_assoc #(
    parameter int WAYS  = 2,
    parameter int SETS  = 8,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);
    localparam int IW = $clog2(SETS);
    localparam int OB = $clog2(WORDS);
    localparam int BW = (OB > 0) ? OB : 1;
    localparam int AB = $clog2(WAYS);
    localparam int AW = (AB > 0) ? AB : 1;
    localparam int TW = 30 - IW - OB;

`ifdef DCACHE_HITCOUNT_EN
    typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH, HALTED, COUNT} state_t;
`else
    typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH, HALTED} state_t;
`endif

    logic          r_valid [SETS][WAYS];
    logic          r_dirty [SETS][WAYS];
    logic [TW-1:0] r_tag   [SETS][WAYS];
    logic [AW-1:0] r_age   [SETS][WAYS];
    logic [31:0]   r_data  [SETS][WAYS][WORDS];

    state_t        r_state, w_next;
    logic [IW-1:0] r_idx;
    logic [AW-1:0] r_way;
    logic [TW-1:0] r_reqtag;
    logic [BW-1:0] r_beat;
    logic          r_missed;
`ifdef DCACHE_HITCOUNT_EN
    logic [31:0]   r_hitcnt;
`endif

    logic [TW-1:0] w_tag;
    logic [IW-1:0] w_idx;
    logic [BW-1:0] w_off;
    logic [1:0]    w_unused_bits;
    logic          w_any, w_found, w_hit, w_miss, w_last, w_fl_dirty, w_fl_end;
    logic [AW-1:0] w_hway, w_vway;

    assign w_tag         = dmemaddr[31 -: TW];
    assign w_idx         = dmemaddr[2 + OB +: IW];
    assign w_unused_bits = dmemaddr[1:0];
    if (OB > 0) begin : g_off
        assign w_off = dmemaddr[2 +: BW];
    end else begin : g_nooff
        assign w_off = '0;
    end

    function automatic logic [31:0] mkaddr(input logic [TW-1:0] t, input logic [IW-1:0] i,
                                           input logic [BW-1:0] b);
        return (32'(t) << (IW + OB + 2)) | (32'(i) << (OB + 2)) | (32'(b) << 2);
    endfunction

    // Hit way is the lowest matching way; victim is lowest invalid way, else the oldest.
    always_comb begin
        w_any   = 1'b0;
        w_hway  = '0;
        w_found = 1'b0;
        w_vway  = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag) && !w_any) begin
                w_hway = AW'(w);
                w_any  = 1'b1;
            end
            if (!r_valid[w_idx][w] && !w_found) begin
                w_vway  = AW'(w);
                w_found = 1'b1;
            end
        end
        if (!w_found) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (r_age[w_idx][w] == AW'(WAYS - 1)) w_vway = AW'(w);
            end
        end
    end

    assign w_hit      = (r_state == IDLE) && !halt && (dmemREN || dmemWEN) && w_any;
    assign w_miss     = (r_state == IDLE) && !halt && (dmemREN || dmemWEN) && !w_any;
    assign w_last     = (r_beat == BW'(WORDS - 1));
    assign w_fl_dirty = r_valid[r_idx][r_way] && r_dirty[r_idx][r_way];
    assign w_fl_end   = (r_idx == IW'(SETS - 1)) && (r_way == AW'(WAYS - 1));

    always_ff @(posedge CLK) begin
        if (!nRST) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        dhit     = 1'b0;
        dmemload = '0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        case (r_state)
            IDLE: begin
                if (halt) begin
                    w_next = FLUSH;
                end else if (w_hit) begin
                    dhit     = 1'b1;
                    dmemload = r_data[w_idx][w_hway][w_off];
                end else if (w_miss) begin
                    w_next = (r_valid[w_idx][w_vway] && r_dirty[w_idx][w_vway]) ? WB : FILL;
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = mkaddr(r_tag[r_idx][r_way], r_idx, r_beat);
                dstore = r_data[r_idx][r_way][r_beat];
                if (!dwait && w_last) w_next = FILL;
            end
            FILL: begin
                dREN  = 1'b1;
                daddr = mkaddr(r_reqtag, r_idx, r_beat);
                if (!dwait && w_last) w_next = IDLE;
            end
            FLUSH: begin
                if (w_fl_dirty) begin
                    dWEN   = 1'b1;
                    daddr  = mkaddr(r_tag[r_idx][r_way], r_idx, r_beat);
                    dstore = r_data[r_idx][r_way][r_beat];
                end
                if ((!w_fl_dirty || (!dwait && w_last)) && w_fl_end) begin
`ifdef DCACHE_HITCOUNT_EN
                    w_next = COUNT;
`else
                    w_next = HALTED;
`endif
                end
            end
            HALTED: flushed = 1'b1;
`ifdef DCACHE_HITCOUNT_EN
            COUNT: begin
                dWEN   = 1'b1;
                daddr  = 32'h0000_3100;
                dstore = r_hitcnt;
                if (!dwait) w_next = HALTED;
            end
`endif
            default: w_next = IDLE;
        endcase
        // Asserted reset kills any memory request combinationally.
        if (!nRST) begin
            dhit     = 1'b0;
            dmemload = '0;
            flushed  = 1'b0;
            dREN     = 1'b0;
            dWEN     = 1'b0;
            daddr    = '0;
            dstore   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                    r_age[s][w]   <= AW'(w);
                end
            end
            r_idx    <= '0;
            r_way    <= '0;
            r_reqtag <= '0;
            r_beat   <= '0;
            r_missed <= 1'b0;
`ifdef DCACHE_HITCOUNT_EN
            r_hitcnt <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (halt) begin
                        r_idx  <= '0;
                        r_way  <= '0;
                        r_beat <= '0;
                    end else if (w_hit) begin
                        for (int unsigned w = 0; w < WAYS; w++) begin
                            if (AW'(w) == w_hway)
                                r_age[w_idx][w] <= '0;
                            else if (r_age[w_idx][w] < r_age[w_idx][w_hway])
                                r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
                        end
                        if (dmemWEN) begin
                            r_data[w_idx][w_hway][w_off] <= dmemstore;
                            r_dirty[w_idx][w_hway]       <= 1'b1;
                        end
                        r_missed <= 1'b0;
`ifdef DCACHE_HITCOUNT_EN
                        if (!r_missed) r_hitcnt <= r_hitcnt + 32'd1;
`endif
                    end else if (w_miss) begin
                        r_idx    <= w_idx;
                        r_way    <= w_vway;
                        r_reqtag <= w_tag;
                        r_beat   <= '0;
                        r_missed <= 1'b1;
`ifdef DCACHE_HITCOUNT_EN
                        r_hitcnt <= r_hitcnt - 32'd1;
`endif
                    end
                end
                WB: begin
                    if (!dwait) begin
                        if (w_last) begin
                            r_beat               <= '0;
                            r_dirty[r_idx][r_way] <= 1'b0;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (!dwait) begin
                        r_data[r_idx][r_way][r_beat] <= dload;
                        if (w_last) begin
                            r_beat                <= '0;
                            r_tag[r_idx][r_way]   <= r_reqtag;
                            r_valid[r_idx][r_way] <= 1'b1;
                            r_dirty[r_idx][r_way] <= 1'b0;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (!w_fl_dirty || (!dwait && w_last)) begin
                        r_valid[r_idx][r_way] <= 1'b0;
                        r_dirty[r_idx][r_way] <= 1'b0;
                        r_beat                <= '0;
                        if (r_way == AW'(WAYS - 1)) begin
                            r_way <= '0;
                            r_idx <= r_idx + 1'b1;
                        end else begin
                            r_way <= r_way + 1'b1;
                        end
                    end else if (!dwait) begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: randomized accesses against an LRU-list cache model and a behavioural memory;
// checks hit timing, load data, every memory beat, flush order and reset abort.
module tb_dcache_assoc;
    localparam int WAYS  = 2;
    localparam int SETS  = 8;
    localparam int WORDS = 2;

    logic        CLK = 1'b0;
    logic        nRST, halt, dmemREN, dmemWEN, dwait;
    logic [31:0] dmemaddr, dmemstore, dload;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;

    always #5 CLK = ~CLK;

    dcache_assoc #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
        .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural memory: unwritten words return an address-derived pattern.
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'd2654435761) ^ 32'h1357_9BDF;
    endfunction

    // Cache model: per-set recency list (front = most recent).
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS][WORDS];
    int          m_order [SETS][$];
    int          m_cnt;

    logic [31:0] e_addr [$];
    bit          e_wen  [$];
    logic [31:0] e_data [$];

    bit          have_prev;
    logic [31:0] p_addr, p_store;
    logic        p_ren, p_wen;
    int          stall_n = 0;

    function automatic logic [31:0] line_addr(input int unsigned t, input int unsigned s,
                                              input int unsigned b);
        return 32'(((t * SETS + s) * WORDS + b) * 4);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_order[s].delete();
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_order[s].push_back(w);
            end
        end
        m_cnt = 0;
        e_addr.delete(); e_wen.delete(); e_data.delete();
        have_prev = 0;
    endtask

    task automatic touch(input int s, input int w);
        for (int i = 0; i < m_order[s].size(); i++) begin
            if (m_order[s][i] == w) begin
                m_order[s].delete(i);
                break;
            end
        end
        m_order[s].push_front(w);
    endtask

    task automatic do_reset();
        nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        dmemaddr = '0; dmemstore = '0; dwait = 1'b1; dload = '0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        model_reset();
    endtask

    // Called at a negedge with a memory request visible; returns 1 ns after the next posedge.
    task automatic serve_beat(output bit acc, output bit was_wen, output logic [31:0] was_addr);
        logic [31:0] a, st, ea, ed;
        logic        ren, wen, w;
        bit          ew;
        a = daddr; st = dstore; ren = dREN; wen = dWEN;
        was_wen = wen; was_addr = a;
        check("dhit_while_busy", 32'(dhit), 32'd0);
        if (have_prev) begin
            check("hold_addr", a, p_addr);
            check("hold_ctl", {30'd0, ren, wen}, {30'd0, p_ren, p_wen});
            if (wen) check("hold_data", st, p_store);
        end
        if (stall_n > 0) begin
            w = 1'b1;
            stall_n--;
        end else begin
            w = ($urandom_range(0, 3) == 0);
        end
        dwait = w;
        dload = w ? $urandom : mem_rd(a);
        @(posedge CLK);
        #1;
        acc = !w;
        if (!w) begin
            have_prev = 0;
            check("beat_expected", 32'(e_addr.size() > 0), 32'd1);
            if (e_addr.size() > 0) begin
                ea = e_addr.pop_front(); ew = e_wen.pop_front(); ed = e_data.pop_front();
                check("beat_addr", a, ea);
                check("beat_dir", {31'd0, wen}, {31'd0, ew});
                if (ew) check("beat_wdata", st, ed);
            end
            if (wen) mem[a] = st;
        end else begin
            have_prev = 1; p_addr = a; p_store = st; p_ren = ren; p_wen = wen;
        end
        dwait = 1'b1;
    endtask

    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        int unsigned s, o, t, cyc;
        int          hw, vw;
        bit          hit, done, acc, bw;
        logic [31:0] ba;
        s = (addr / (4 * WORDS)) % SETS;
        o = (addr / 4) % WORDS;
        t = addr / (4 * WORDS * SETS);
        hit = 0; hw = 0;
        for (int w = 0; w < WAYS; w++)
            if (!hit && m_valid[s][w] && m_tag[s][w] == t) begin hit = 1; hw = w; end
        if (!hit) begin
            vw = -1;
            for (int w = 0; w < WAYS; w++) if (vw < 0 && !m_valid[s][w]) vw = w;
            if (vw < 0) vw = m_order[s][m_order[s].size() - 1];
            if (m_valid[s][vw] && m_dirty[s][vw])
                for (int b = 0; b < WORDS; b++) begin
                    e_addr.push_back(line_addr(m_tag[s][vw], s, b));
                    e_wen.push_back(1);
                    e_data.push_back(m_data[s][vw][b]);
                end
            for (int b = 0; b < WORDS; b++) begin
                e_addr.push_back(line_addr(t, s, b));
                e_wen.push_back(0);
                e_data.push_back('0);
                m_data[s][vw][b] = mem_rd(line_addr(t, s, b));
            end
            m_valid[s][vw] = 1; m_dirty[s][vw] = 0; m_tag[s][vw] = t;
            hw = vw;
            m_cnt--;
        end else begin
            m_cnt++;
        end
        touch(s, hw);
        if (we) begin
            m_data[s][hw][o] = wd;
            m_dirty[s][hw] = 1;
        end

        dmemREN = !we; dmemWEN = we; dmemaddr = addr; dmemstore = wd;
        @(negedge CLK);
        check("hit_first_cycle", 32'(dhit), 32'(hit));
        cyc = 0; done = 0;
        while (!done) begin
            if (dREN || dWEN) begin
                serve_beat(acc, bw, ba);
            end else if (dhit) begin
                if (!we) check("load_data", dmemload, m_data[s][hw][o]);
                check("beats_left", 32'(e_addr.size()), 32'd0);
                @(posedge CLK);
                #1 done = 1;
            end else begin
                @(posedge CLK);
                #1;
            end
            if (!done) begin
                cyc++;
                if (cyc > 200) begin
                    check("access_timeout", 32'(dhit), 32'd1);
                    e_addr.delete(); e_wen.delete(); e_data.delete();
                    done = 1;
                end else begin
                    @(negedge CLK);
                end
            end
        end
        dmemREN = 1'b0; dmemWEN = 1'b0;
    endtask

    task automatic do_flush();
        int unsigned cyc, n_wb;
        bit          acc, bw;
        logic [31:0] ba;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                if (m_valid[s][w] && m_dirty[s][w])
                    for (int b = 0; b < WORDS; b++) begin
                        e_addr.push_back(line_addr(m_tag[s][w], s, b));
                        e_wen.push_back(1);
                        e_data.push_back(m_data[s][w][b]);
                    end
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
            end
`ifdef DCACHE_HITCOUNT_EN
        e_addr.push_back(32'h0000_3100);
        e_wen.push_back(1);
        e_data.push_back(32'(m_cnt));
`endif
        halt = 1'b1;
        n_wb = 0; cyc = 0;
        @(negedge CLK);
        while (!flushed && cyc < 500) begin
            if (dREN || dWEN) begin
                serve_beat(acc, bw, ba);
                if (acc && bw && ba != 32'h0000_3100) n_wb++;
            end else begin
                @(posedge CLK);
                #1;
            end
            if (cyc == 3) halt = 1'b0;
            cyc++;
            @(negedge CLK);
        end
        check("flushed_set", 32'(flushed), 32'd1);
        check("flush_beats_left", 32'(e_addr.size()), 32'd0);
        check("flush_wb_beats", n_wb, 32'(2 * WORDS));
        dmemREN = 1'b1; dmemaddr = 32'h0000_0008;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("halted_flushed", 32'(flushed), 32'd1);
            check("halted_quiet", {29'd0, dREN, dWEN, dhit}, 32'd0);
        end
        dmemREN = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned cyc;
        do_reset();
        @(negedge CLK);
        check("rst_dhit", 32'(dhit), 32'd0);
        check("rst_dREN", 32'(dREN), 32'd0);
        check("rst_dWEN", 32'(dWEN), 32'd0);
        check("rst_flushed", 32'(flushed), 32'd0);
        check("rst_dmemload", dmemload, 32'd0);
        @(posedge CLK); #1;

        // Clean miss then same-line hit.
        mem[32'h40] = 32'hAAAA_0000;
        mem[32'h44] = 32'hAAAA_0001;
        access(0, 32'h40, 0);
        access(0, 32'h44, 0);

        // Dirty LRU eviction in set 0.
        do_reset();
        access(1, 32'h000, 32'h11);
        access(0, 32'h040, 0);
        access(0, 32'h080, 0);

        // LRU victim choice in set 3.
        access(0, 32'h58, 0);
        access(0, 32'h98, 0);
        access(0, 32'h58, 0);
        access(0, 32'h98, 0);
        access(0, 32'h58, 0);
        access(0, 32'hD8, 0);
        access(0, 32'h58, 0);
        access(0, 32'h98, 0);

        // Long memory stall on a fill beat.
        stall_n = 5;
        access(0, 32'h1F0, 0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, SETS - 1) << 3)
                | ($urandom_range(0, WORDS - 1) << 2);
            access($urandom_range(0, 1) == 1, a, $urandom);
        end

        // Reset in the middle of a write-back.
        do_reset();
        access(1, 32'h050, 32'h1234_5678);
        access(1, 32'h090, 32'h9ABC_DEF0);
        access(0, 32'h050, 0);
        dmemREN = 1'b1; dmemaddr = 32'h0D0;
        cyc = 0;
        @(negedge CLK);
        while (!dWEN && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        check("wb_started", 32'(dWEN), 32'd1);
        nRST = 1'b0;
        @(posedge CLK); #1;
        check("rst_abort_dWEN", 32'(dWEN), 32'd0);
        check("rst_abort_dREN", 32'(dREN), 32'd0);
        nRST = 1'b1; dmemREN = 1'b0;
        model_reset();
        access(0, 32'h0D0, 0);
        access(0, 32'h050, 0);

        // Dirty lines in sets 1 and 5 plus a clean line, then flush.
        do_reset();
        access(1, 32'h008, 32'hCAFE_0001);
        access(1, 32'h02C, 32'hCAFE_0005);
        access(0, 32'h010, 0);
        access(0, 32'h02C, 0);
        do_flush();

        $display("model hit-minus-miss count %0d", m_cnt);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
